// File: rtl/mem_dp_resp.sv
// Dual-port data-memory responder: captures MA addresses ping-pong style and services
// MO 24/48-bit accesses from split even/odd word banks, with an optional post-reset clear.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif

module mem_dp_resp #(
    parameter int unsigned DEPTH_LOG2     = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                    iw_clk,
    input  logic                    iw_rst,
    input  logic                    iw_mem_mp,
    input  logic [`SIZE_ADDR-1:0]   iw_mem_addr [0:1],
    input  logic                    iw_mem_we,
    input  logic                    iw_mem_wide,
    input  logic [2*`SIZE_DATA-1:0] iw_mem_wdata,
    output logic [2*`SIZE_DATA-1:0] ow_mem_rdata,
    output logic                    ow_mem_ready,
    output logic                    ow_mem_fault,
    output logic                    ow_mp_err
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned ROWS  = DEPTH / 2;
    localparam int unsigned RW    = (DEPTH_LOG2 > 1) ? DEPTH_LOG2 - 1 : 1;
    localparam logic [`SIZE_ADDR-1:0] LAST_WORD = `SIZE_ADDR'(DEPTH - 1);
    localparam logic [RW-1:0]         LAST_ROW  = RW'(ROWS - 1);

    typedef enum logic {StClear, StRun} state_e;

    state_e                 r_state;
    logic [RW-1:0]          r_cnt;
    logic                   r_ready;
    logic                   r_mp_exp;
    logic                   r_mp_err;
    logic [`SIZE_ADDR-1:0]  r_addr [0:1];

    logic [`SIZE_DATA-1:0]  mem_even [ROWS];
    logic [`SIZE_DATA-1:0]  mem_odd  [ROWS];

    logic [`SIZE_ADDR-1:0]  a;
    logic [`SIZE_ADDR-1:0]  a_nxt;
    logic [`SIZE_ADDR-1:0]  a_hi;
    logic                   fault_raw;
    logic                   acc_ok;
    logic                   wr_en;
    logic [RW-1:0]          row_a;
    logic [RW-1:0]          row_a1;
    logic [RW-1:0]          even_row;
    logic [RW-1:0]          odd_row;
    logic [`SIZE_DATA-1:0]  lo_word;
    logic [`SIZE_DATA-1:0]  hi_word;
    logic [`SIZE_DATA-1:0]  wd_lo;
    logic [`SIZE_DATA-1:0]  wd_hi;

    assign a         = iw_mem_mp ? r_addr[1] : r_addr[0];
    assign a_nxt     = a + 1'b1;
    assign a_hi      = a >> DEPTH_LOG2;
    // No wrap-around: a wide access may not start on the last word.
    assign fault_raw = (|a_hi) | (iw_mem_wide & (a == LAST_WORD));
    assign acc_ok    = r_ready & ~fault_raw;
    assign wr_en     = iw_mem_we & acc_ok;

    // Word a+1 of an even a shares its row with a in the odd bank; for odd a it sits in
    // the next even row.
    assign row_a    = RW'(a >> 1);
    assign row_a1   = RW'(a_nxt >> 1);
    assign even_row = a[0] ? row_a1 : row_a;
    assign odd_row  = row_a;

    assign lo_word = a[0] ? mem_odd[odd_row] : mem_even[even_row];
    assign hi_word = a[0] ? mem_even[even_row] : mem_odd[odd_row];
    assign wd_lo   = iw_mem_wdata[`SIZE_DATA-1:0];
    assign wd_hi   = iw_mem_wdata[2*`SIZE_DATA-1:`SIZE_DATA];

    always_comb begin
        ow_mem_rdata = '0;
        if (acc_ok) begin
            ow_mem_rdata[`SIZE_DATA-1:0] = lo_word;
            if (iw_mem_wide) begin
                ow_mem_rdata[2*`SIZE_DATA-1:`SIZE_DATA] = hi_word;
            end
        end
    end

    assign ow_mem_fault = r_ready & fault_raw;
    assign ow_mem_ready = r_ready;
    assign ow_mp_err    = r_mp_err;

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_addr[0] <= '0;
            r_addr[1] <= '0;
            r_mp_exp  <= 1'b0;
            r_mp_err  <= 1'b0;
        end else begin
            if (iw_mem_mp) begin
                r_addr[0] <= iw_mem_addr[0];
            end else begin
                r_addr[1] <= iw_mem_addr[1];
            end
            r_mp_exp <= ~r_mp_exp;
            if (iw_mem_mp != r_mp_exp) begin
                r_mp_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_state <= CLEAR_ON_RESET ? StClear : StRun;
            r_cnt   <= '0;
            r_ready <= ~CLEAR_ON_RESET;
        end else begin
            case (r_state)
                StClear: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ROW) begin
                        r_state <= StRun;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StRun;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge iw_clk) begin
        if (r_state == StClear) begin
            mem_even[r_cnt] <= '0;
            mem_odd[r_cnt]  <= '0;
        end else if (wr_en) begin
            if (~a[0] | iw_mem_wide) begin
                mem_even[even_row] <= a[0] ? wd_hi : wd_lo;
            end
            if (a[0] | iw_mem_wide) begin
                mem_odd[odd_row] <= a[0] ? wd_lo : wd_hi;
            end
        end
    end

endmodule
